// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle restoring divider for MIPS DIV/DIVU in the
//                execute stage. One quotient bit is produced per cycle, so a
//                divide takes WIDTH iterations. Signed operands are reduced to
//                magnitudes on entry, and the signs are re-applied when the
//                result is written.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                start      - divide request (divE), honoured only when idle
//                signed_div - 1 = DIV (two's complement), 0 = DIVU
//                cancel     - abort the divide in flight (exception/flush)
//                a, b       - dividend / divisor, sampled with start
//                busy       - high while iterating (divbusyE to hazard unit)
//                done       - one-cycle pulse when lo/hi hold a new result
//                lo, hi     - quotient / remainder, held until the next done
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;       // iteration counter
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    // Magnitudes; the most negative value maps to itself and is then treated
    // as an unsigned number, which gives the architected overflow result.
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    assign w_a_mag = a[WIDTH-1] ? (-a) : a;
    assign w_b_mag = b[WIDTH-1] ? (-b) : b;

    // One restoring step. The shifted remainder is WIDTH+1 bits so the bit
    // shifted out of the top is kept for the compare/subtract.
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;

    assign w_rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, dvs_q};
    assign w_ge       = (w_rem_sh >= {1'b0, dvs_q});
    assign w_rem_step = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_step = {quo_q[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        lo_d      = lo_q;
        hi_d      = hi_q;

        case (state_q)
            S_IDLE: begin
                // cancel outranks a simultaneous start
                if (start && !cancel) begin
                    quo_d     = signed_div ? w_a_mag : a;
                    dvs_d     = signed_div ? w_b_mag : b;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = signed_div & a[WIDTH-1];
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = w_quo_step;
                    rem_d = w_rem_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        // Results are published on the edge entering DONE,
                        // straight from the final step.
                        lo_d    = neg_quo_q ? (-w_quo_step) : w_quo_step;
                        hi_d    = neg_rem_q ? (-w_rem_step) : w_rem_step;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_div;
    logic         cancel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .cancel     (cancel),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .lo         (lo),
        .hi         (hi)
    );

    always #5 clk = ~clk;

    // Present a one-cycle start pulse; returns at the negedge after the
    // accepting posedge.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic sg);
        @(negedge clk);
        a          = ta;
        b          = tb_v;
        signed_div = sg;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Counts busy cycles until done is seen (bounded).
    task automatic wait_done(output int bcnt, output bit got);
        bcnt = 0;
        got  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; a = '0; b = '0;
        #1;
        n_checks++;
        if ({busy, done, lo, hi} !== {2'b00, {W{1'b0}}, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b lo=%h hi=%h, required all zero", busy, done, lo, hi);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_divu_basic();
        int bcnt;
        bit got;
        launch(32'd100, 32'd7, 1'b0);
        wait_done(bcnt, got);
        n_checks++;
        if (!got || bcnt != 32) begin
            n_fail++;
            $display("FAIL divu_latency: got_done=%0d busy_cycles=%0d, required 1 and 32", got, bcnt);
        end
        n_checks++;
        if (lo !== 32'd14 || hi !== 32'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL divu_100_7: lo=%0d hi=%0d busy=%b, required lo=14 hi=2 busy=0", lo, hi, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b lo=%0d hi=%0d, required done=0 lo=14 hi=2", done, lo, hi);
        end
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         sg;
        logic [W-1:0] elo;
        logic [W-1:0] ehi;
    } vec_t;

    task automatic test_vectors();
        vec_t v[7];
        int   bcnt;
        bit   got;
        v[0] = '{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF}; // -7/2
        v[1] = '{32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001}; // 7/-2
        v[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000}; // overflow
        v[3] = '{32'h0000_0005, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0005}; // 5/0 unsigned
        v[4] = '{32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 32'h0000_0001, 32'hFFFF_FFF9}; // -7/0 signed
        v[5] = '{32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h7FFF_FFFC, 32'h0000_0001}; // divu big
        v[6] = '{32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'h0000_0002, 32'hFFFF_FFFE}; // -8/-3
        for (int i = 0; i < 7; i++) begin
            launch(v[i].va, v[i].vb, v[i].sg);
            wait_done(bcnt, got);
            n_checks++;
            if (!got || bcnt != 32 || lo !== v[i].elo || hi !== v[i].ehi) begin
                n_fail++;
                $display("FAIL vector%0d: done=%0d busy=%0d lo=%h hi=%h, required 1 32 lo=%h hi=%h",
                         i, got, bcnt, lo, hi, v[i].elo, v[i].ehi);
            end
        end
    endtask

    task automatic test_start_ignored();
        int bcnt = 0;
        bit got  = 1'b0;
        launch(32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
            if (busy && bcnt == 10) begin
                start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!got || bcnt != 32 || lo !== 32'd14 || hi !== 32'd2) begin
            n_fail++;
            $display("FAIL start_while_busy: done=%0d busy=%0d lo=%0d hi=%0d, required 1 32 14 2", got, bcnt, lo, hi);
        end
        // start while done must not be accepted
        start = 1'b1; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_cancel();
        int  bcnt = 0;
        bit  seen = 1'b0;
        bit  got;
        launch(32'd1000, 32'd3, 1'b0);
        for (int i = 0; i < 20 && bcnt < 15; i++) begin
            if (busy) bcnt++;
            if (bcnt < 15) @(negedge clk);
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
            n_fail++;
            $display("FAIL cancel_run: busy=%b done=%b lo=%0d hi=%0d, required 0 0 14 2", busy, done, lo, hi);
        end
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL cancel_quiet: activity=%0d after cancel, required 0", seen);
        end
        // cancel together with start in IDLE: nothing accepted
        start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd2; signed_div = 1'b0;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_with_start: busy=%b, required 0", busy);
        end
        launch(32'd1000, 32'd3, 1'b0);
        wait_done(bcnt, got);
        n_checks++;
        if (!got || bcnt != 32 || lo !== 32'd333 || hi !== 32'd1) begin
            n_fail++;
            $display("FAIL restart_after_cancel: done=%0d busy=%0d lo=%0d hi=%0d, required 1 32 333 1", got, bcnt, lo, hi);
        end
    endtask

    task automatic test_reset_mid();
        int bcnt;
        bit got;
        launch(32'd50, 32'd6, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, lo, hi} !== {2'b00, {W{1'b0}}, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b done=%b lo=%h hi=%h, required all zero", busy, done, lo, hi);
        end
        @(negedge clk);
        rst = 1'b0;
        launch(32'd50, 32'd6, 1'b0);
        wait_done(bcnt, got);
        n_checks++;
        if (!got || lo !== 32'd8 || hi !== 32'd2) begin
            n_fail++;
            $display("FAIL after_reset_div: done=%0d lo=%0d hi=%0d, required 1 8 2", got, lo, hi);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tb_v, elo, ehi;
        logic         sg;
        longint       sa, sb, q, r;
        int           bcnt;
        bit           got;
        for (int i = 0; i < 20; i++) begin
            ta   = $urandom;
            tb_v = $urandom_range(0, 1) ? $urandom : $urandom_range(1, 1000);
            if ($urandom_range(0, 1)) tb_v = -tb_v;
            if (tb_v == '0) tb_v = 32'd1;
            sg = 1'($urandom_range(0, 1));
            if (sg) begin
                sa  = longint'($signed(ta));
                sb  = longint'($signed(tb_v));
                q   = sa / sb;
                r   = sa % sb;
                elo = q[W-1:0];
                ehi = r[W-1:0];
            end else begin
                elo = ta / tb_v;
                ehi = ta % tb_v;
            end
            launch(ta, tb_v, sg);
            wait_done(bcnt, got);
            n_checks++;
            if (!got || lo !== elo || hi !== ehi) begin
                n_fail++;
                $display("FAIL random%0d sg=%0d %h/%h: lo=%h hi=%h, required lo=%h hi=%h",
                         i, sg, ta, tb_v, lo, hi, elo, ehi);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_vectors();
        test_start_ignored();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
